// File: rtl/cache_bus_arbiter_pkg.sv
// Shared definitions for the cache bus arbiter.
// Holds the FSM state encoding, the owner (requester) encoding and the
// sram-like access size codes used by the arbiter and its grant logic.
package cache_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAddr = 2'd1,
    StData = 2'd2
  } state_e;

  typedef enum logic {
    OwnerInst = 1'b0,
    OwnerData = 1'b1
  } owner_e;

  localparam logic [1:0] SizeByte = 2'd0;
  localparam logic [1:0] SizeHalf = 2'd1;
  localparam logic [1:0] SizeWord = 2'd2;

endpackage

// File: rtl/rr_arb2.sv
// Two-way grant logic for the cache bus arbiter.
// Ports:
//   req[1:0] - request vector, bit 0 = inst, bit 1 = data
//   last     - requester granted most recently (0 inst, 1 data)
//   rr       - 1 selects round-robin on ties, 0 selects fixed data priority
//   grant    - selected requester (0 inst, 1 data); meaningless when req == 0
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       rr,
  output logic       grant
);

  always_comb begin
    grant = 1'b0;
    case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      // Tie: round-robin hands it to whoever did not win last time.
      2'b11:   grant = rr ? ~last : 1'b1;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/cache_bus_arbiter.sv
// Arbiter joining an i-cache and a d-cache sram-like port onto one shared
// sram-like master port, with exactly one outstanding transaction.
// Ports:
//   clk, resetn                      - clock, asynchronous active-low reset
//   inst_* / data_* (inputs)         - requester req/wr/size/addr/wdata
//   inst_* / data_* (outputs)        - rdata and addr_ok/data_ok acknowledges
//   mem_req/wr/size/addr/wdata (out) - shared master request, from latched fields
//   mem_rdata/addr_ok/data_ok (in)   - shared master responses
module cache_bus_arbiter
  import cache_bus_arbiter_pkg::*;
#(
  parameter bit RR = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok
);

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  owner_e      last_q, last_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        arb_grant;
  logic        own_addr_ok;
  logic        own_data_ok;

  rr_arb2 u_rr_arb2 (
    .req   ({data_req, inst_req}),
    .last  (last_q),
    .rr    (RR),
    .grant (arb_grant)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    wr_d        = wr_q;
    size_d      = size_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mem_req     = 1'b0;
    own_addr_ok = 1'b0;
    own_data_ok = 1'b0;

    case (state_q)
      StIdle: begin
        // Stray mem acks here belong to no transaction and are ignored.
        if (inst_req || data_req) begin
          owner_d = owner_e'(arb_grant);
          last_d  = owner_e'(arb_grant);
          if (arb_grant) begin
            wr_d    = data_wr;
            size_d  = data_size;
            addr_d  = data_addr;
            wdata_d = data_wdata;
          end else begin
            wr_d    = inst_wr;
            size_d  = inst_size;
            addr_d  = inst_addr;
            wdata_d = inst_wdata;
          end
          state_d = StAddr;
        end
      end
      StAddr: begin
        mem_req = 1'b1;
        if (mem_addr_ok) begin
          own_addr_ok = 1'b1;
          if (mem_data_ok) begin
            own_data_ok = 1'b1;
            state_d     = StIdle;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (mem_data_ok) begin
          own_data_ok = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      owner_q <= OwnerInst;
      last_q  <= OwnerInst;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Request fields come only from the latched copy so they stay stable
  // while the requester moves on.
  assign mem_wr    = wr_q;
  assign mem_size  = size_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign inst_addr_ok = own_addr_ok && (owner_q == OwnerInst);
  assign inst_data_ok = own_data_ok && (owner_q == OwnerInst);
  assign data_addr_ok = own_addr_ok && (owner_q == OwnerData);
  assign data_data_ok = own_data_ok && (owner_q == OwnerData);

endmodule
